// File: rtl/data_in_pkg.sv
// Shared definitions for the data-in write path arbiter.
package data_in_pkg;

  // Default width of the data and address buses.
  localparam int unsigned DATA_W = 32;

  // Source tag carried alongside each buffered write.
  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  // Starvation counter width; the limit is at most 15.
  localparam int unsigned CNT_W = 4;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive cycles in which req1 was left waiting.
// sat is asserted once the count reaches LIMIT and stays there until cleared.
module starve_counter
  import data_in_pkg::*;
#(
  parameter int unsigned LIMIT = 4  // legal range 1..15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [CNT_W-1:0] LimitVal = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LimitVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == LimitVal);

endmodule

// File: rtl/data_in_arbiter.sv
// Two-requester arbiter for the 32-bit data-in write path. req0 (store port)
// has priority; req1 (loader/debug) is forced through after STARVE_LIMIT blocked
// cycles. The winner is buffered in a one-entry output register with
// valid/ready toward memory.
module data_in_arbiter #(
  parameter int unsigned DATA_W       = data_in_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              mux_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  import data_in_pkg::*;

  state_e            state_q;
  logic [DATA_W-1:0] addr_q, data_q;
  logic              src_q;

  logic              can_accept;
  logic              force_gnt;
  logic              gnt0, gnt1;
  logic              accept;
  logic              req1_acc;
  logic [DATA_W-1:0] sel_addr, sel_data;

  // Per-cycle grant; everything is held off while in reset.
  always_comb begin
    can_accept = (state_q == ST_EMPTY) | out_ready;
    gnt1       = resetn & req1_valid & (force_gnt | ~req0_valid);
    gnt0       = resetn & req0_valid & ~gnt1;
    accept     = (gnt0 | gnt1) & can_accept;
    req1_acc   = req1_valid & gnt1 & can_accept;
  end

  assign mux_sel    = gnt1;
  assign req0_ready = gnt0 & can_accept;
  assign req1_ready = gnt1 & can_accept;

  // 2:1 address/data mux steered by the grant.
  assign sel_addr = mux_sel ? req1_addr : req0_addr;
  assign sel_data = mux_sel ? req1_data : req0_data;

  // req1 waiting without being taken counts up (including output backpressure);
  // taking it or dropping its valid clears the count.
  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .clr    (~req1_valid | req1_acc),
    .inc    (req1_valid & ~req1_acc),
    .sat    (force_gnt)
  );

  // Output register FSM: reload on accept, empty on drain without a new accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      src_q   <= SRC_REQ0;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_FULL;
        ST_FULL:  if (!accept && out_ready) state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        src_q  <= gnt1 ? SRC_REQ1 : SRC_REQ0;
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_data_in_arbiter.sv
// Self-checking bench for data_in_arbiter: directed checks per scenario plus a
// scoreboard that tracks every accepted write through the output register.
module tb_data_in_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_addr, req0_data, req1_addr, req1_data;
  logic          req0_ready, req1_ready, mux_sel;
  logic          out_valid, out_ready, out_src;
  logic [DW-1:0] out_addr, out_data;

  always #5 clk = ~clk;

  data_in_arbiter #(
    .DATA_W       (DW),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .mux_sel    (mux_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t sb_head;
  bit  mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: retire the buffered write on drain, then record a new accept.
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      check_eq("out_valid_vs_sb", out_valid, sb.size() != 0);
      check_eq("ready_onehot", req0_ready & req1_ready, 0);
      if (out_valid && out_ready && sb.size() != 0) begin
        sb_head = sb.pop_front();
        check_eq("sb_src", out_src, sb_head.src);
        check_eq("sb_addr", out_addr, sb_head.addr);
        check_eq("sb_data", out_data, sb_head.data);
      end
      if (req0_valid && req0_ready) sb.push_back(wr_t'{1'b0, req0_addr, req0_data});
      if (req1_valid && req1_ready) sb.push_back(wr_t'{1'b1, req1_addr, req1_data});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic exp1;
  logic [DW-1:0] d0, d1;

  initial begin
    resetn     = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 32'h0000_0010;
    req0_data  = 32'h1111_1111;
    req1_valid = 1'b1;
    req1_addr  = 32'h0000_0020;
    req1_data  = 32'h2222_2222;
    out_ready  = 1'b1;

    // 1: reset held with both requesters valid
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_req0_ready", req0_ready, 0);
      check_eq("rst_req1_ready", req1_ready, 0);
      check_eq("rst_mux_sel", mux_sel, 0);
      check_eq("rst_out_data", out_data, 0);
      next_cycle();
    end
    resetn     = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mon_en     = 1'b1;
    next_cycle();

    // 2: solo req1
    req1_valid = 1'b1;
    req1_addr  = 32'h0000_0100;
    req1_data  = 32'hA5A5_0001;
    @(negedge clk);
    check_eq("solo_req1_ready", req1_ready, 1);
    check_eq("solo_mux_sel", mux_sel, 1);
    check_eq("solo_req0_ready", req0_ready, 0);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("solo_out_valid", out_valid, 1);
    check_eq("solo_out_data", out_data, 32'hA5A5_0001);
    check_eq("solo_out_src", out_src, 1);
    next_cycle();

    // 3: contention, expect 4 req0 grants then one forced req1 grant
    d0 = 32'h0000_1000;
    d1 = 32'h0000_2000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = d0;
    req1_data  = d1;
    for (int i = 0; i < 10; i++) begin
      exp1 = (i % 5) == 4;
      @(negedge clk);
      check_eq("cont_req1_ready", req1_ready, exp1);
      check_eq("cont_req0_ready", req0_ready, !exp1);
      check_eq("cont_mux_sel", mux_sel, exp1);
      next_cycle();
      if (exp1) d1 = d1 + 1;
      else d0 = d0 + 1;
      req0_data = d0;
      req1_data = d1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    next_cycle();

    // 4: backpressure holds the buffered write stable
    req0_valid = 1'b1;
    req0_addr  = 32'h0000_0040;
    req0_data  = 32'h1234_5678;
    @(negedge clk);
    check_eq("bp_first_accept", req0_ready, 1);
    next_cycle();
    req0_data = 32'hCAFE_0002;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_data", out_data, 32'h1234_5678);
      check_eq("bp_out_addr", out_addr, 32'h0000_0040);
      check_eq("bp_req0_ready", req0_ready, 0);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", req0_ready, 1);
    check_eq("bp_release_data", out_data, 32'h1234_5678);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_reload_valid", out_valid, 1);
    check_eq("bp_reload_data", out_data, 32'hCAFE_0002);
    next_cycle();

    // 5: back-to-back writes with no bubble
    req0_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      req0_data = DW'(k);
      @(negedge clk);
      check_eq("b2b_ready", req0_ready, 1);
      if (k > 1) begin
        check_eq("b2b_out_valid", out_valid, 1);
        check_eq("b2b_out_data", out_data, DW'(k - 1));
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_last_valid", out_valid, 1);
    check_eq("b2b_last_data", out_data, 32'h3);
    next_cycle();

    // 6: reset while FULL with req1 partly starved
    out_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 32'hDEAD_0006;
    req1_valid = 1'b1;
    req1_data  = 32'hBEEF_0006;
    @(negedge clk);
    check_eq("mid_accept", req0_ready, 1);
    next_cycle();
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("mid_full", out_valid, 1);
      check_eq("mid_req1_blocked", req1_ready, 0);
      next_cycle();
    end
    resetn = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("mid_rst_req1_ready", req1_ready, 0);
    check_eq("mid_rst_mux_sel", mux_sel, 0);
    next_cycle();
    resetn     = 1'b1;
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    d0 = 32'h0000_6000;
    req0_data = d0;
    for (int i = 0; i < 5; i++) begin
      exp1 = (i == 4);
      @(negedge clk);
      if (i == 0) check_eq("post_rst_out_valid", out_valid, 0);
      check_eq("post_rst_req1_ready", req1_ready, exp1);
      check_eq("post_rst_req0_ready", req0_ready, !exp1);
      next_cycle();
      if (!exp1) d0 = d0 + 1;
      req0_data = d0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      next_cycle();
    end
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
